// File: rtl/req_gnt_pkg.sv
// Shared types and constants for the round-robin request/grant arbiter.
package req_gnt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_e;

    localparam int NREQ_DEF     = 4;
    localparam int MAX_HOLD_DEF = 16;

    // Index width that never collapses to zero bits for tiny counts.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/req_gnt_arbiter_rr_pick.sv
// Rotating priority encoder: first set request at or after ptr, wrapping around.
module rr_pick
    import req_gnt_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   win,
    output logic            found
);

    int k;

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        win   = '0;
        found = 1'b0;
        k     = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = (int'(ptr) + i) % NREQ;
            if (req[k]) begin
                win   = IW'(k);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/req_gnt_arbiter.sv
// Round-robin arbiter: one owner at a time, one-cycle turnaround between owners,
// optional hold limit that preempts an owner while others are waiting.
module req_gnt_arbiter
    import req_gnt_pkg::*;
#(
    parameter int NREQ     = NREQ_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    output logic [NREQ-1:0]          gnt,
    output logic [idx_w(NREQ)-1:0]   gnt_id,
    output logic                     busy,
    output logic                     preempt
);

    localparam int IW = idx_w(NREQ);
    localparam int HW = idx_w(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HW'(MAX_HOLD - 1);

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   gnt_id_q, gnt_id_d;
    logic            busy_q, busy_d;
    logic            preempt_q, preempt_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [HW-1:0]   cnt_q, cnt_d;

    logic [IW-1:0]   win;
    logic            found;
    logic            others_wait;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .win   (win),
        .found (found)
    );

    // The one-hot grant doubles as the owner mask.
    assign others_wait = |(req & ~gnt_q);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        busy_d    = busy_q;
        preempt_d = 1'b0;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE, RELEASE: begin
                if (found) begin
                    state_d  = GRANT;
                    gnt_d    = NREQ'(1) << win;
                    gnt_id_d = win;
                    busy_d   = 1'b1;
                    ptr_d    = IW'((int'(win) + 1) % NREQ);
                    cnt_d    = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (!req[gnt_id_q]) begin
                    state_d = RELEASE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                end else if ((MAX_HOLD != 0) && (cnt_q == HOLD_LAST) && others_wait) begin
                    state_d   = RELEASE;
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    preempt_d = 1'b1;
                end else if (cnt_q != HOLD_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
            ptr_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            busy_q    <= busy_d;
            preempt_q <= preempt_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = busy_q;
    assign preempt = preempt_q;

endmodule

// File: tb/tb_req_gnt_arbiter.sv
// Bench for req_gnt_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against an owner/rotation model.
module tb_req_gnt_arbiter;

    localparam int NREQ     = 4;
    localparam int MAX_HOLD = 16;

    logic            clk;
    logic            rst;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [1:0]      gnt_id;
    logic            busy;
    logic            preempt;

    int checks = 0;
    int errors = 0;

    req_gnt_arbiter #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .preempt (preempt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who owns the resource, for how many cycles, and where
    // the rotation restarts. owner = -1 means nobody holds a grant this cycle.
    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 0;
    bit m_pre   = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_owner <= -1;
            m_held  <= 0;
            m_ptr   <= 0;
            m_pre   <= 1'b0;
        end else begin
            automatic int own  = m_owner;
            automatic int held = m_held;
            automatic int ptr  = m_ptr;
            automatic bit pre  = 1'b0;
            automatic bit hit  = 1'b0;
            if (own >= 0) begin
                if (!req[own]) begin
                    own = -1;
                end else if (held >= MAX_HOLD && ((req & ~(NREQ'(1) << own)) != 0)) begin
                    own = -1;
                    pre = 1'b1;
                end else if (held < MAX_HOLD) begin
                    held = held + 1;
                end
            end else begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!hit && req[(ptr + i) % NREQ]) begin
                        own = (ptr + i) % NREQ;
                        hit = 1'b1;
                    end
                end
                if (hit) begin
                    held = 1;
                    ptr  = (own + 1) % NREQ;
                end
            end
            m_owner <= own;
            m_held  <= held;
            m_ptr   <= ptr;
            m_pre   <= pre;
        end
    end

    logic [NREQ-1:0] prev_gnt = '0;

    always @(negedge clk) begin
        automatic logic [NREQ-1:0] exp_gnt = (m_owner >= 0) ? NREQ'(1) << m_owner : '0;
        check("model_gnt", 32'(gnt), 32'(exp_gnt));
        check("model_busy", 32'(busy), 32'(m_owner >= 0));
        check("model_preempt", 32'(preempt), 32'(m_pre));
        if (m_owner >= 0) check("model_gnt_id", 32'(gnt_id), 32'(m_owner));
        if (gnt != prev_gnt && gnt != '0)
            $display("grant   id=%0d req=%b t=%0t", gnt_id, req, $time);
        if (preempt)
            $display("preempt req=%b t=%0t", req, $time);
        prev_gnt = gnt;
    end

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        int r = -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        req = '0;
        rst = 1'b1;
        #1 rst = 1'b0;

        // Reset with all requests high: nothing granted.
        repeat (3) @(negedge clk);
        req = 4'b1111;
        @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_preempt", 32'(preempt), 32'h0);
        check("rst_gnt_id", 32'(gnt_id), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("first_gnt", 32'(gnt), 32'h1);
        check("first_gnt_id", 32'(gnt_id), 32'h0);

        // Everyone requesting, each owner keeps it 3 cycles: rotation 0,1,2,3,0.
        for (int g = 0; g < 5; g++) begin
            automatic int id;
            automatic int tmo = 0;
            while (gnt == '0 && tmo < 10) begin
                @(negedge clk);
                tmo++;
            end
            id = onehot_idx(gnt);
            check("rr_order", 32'(id), 32'(g % NREQ));
            if (id < 0) id = 0;
            repeat (2) @(negedge clk);
            req[id] = 1'b0;
            @(negedge clk);
            check("rr_gap", 32'(gnt), 32'h0);
            req[id] = 1'b1;
            @(negedge clk);
        end
        req = '0;
        repeat (4) @(negedge clk);

        // Lone owner is never preempted.
        req = 4'b0100;
        @(negedge clk);
        for (int c = 0; c < 40; c++) begin
            check("lone_gnt", 32'(gnt), 32'h4);
            check("lone_preempt", 32'(preempt), 32'h0);
            @(negedge clk);
        end
        req = '0;
        repeat (4) @(negedge clk);

        // Owner 1 preempted after 16 cycles once master 3 waits.
        req = 4'b0010;
        @(negedge clk);
        for (int c = 1; c <= MAX_HOLD; c++) begin
            check("hold_gnt", 32'(gnt), 32'h2);
            if (c == 5) req[3] = 1'b1;
            @(negedge clk);
        end
        check("preempt_gap_gnt", 32'(gnt), 32'h0);
        check("preempt_pulse", 32'(preempt), 32'h1);
        @(negedge clk);
        check("preempt_next_gnt", 32'(gnt), 32'h8);
        check("preempt_single", 32'(preempt), 32'h0);
        req = '0;
        repeat (4) @(negedge clk);

        // A withdrawn request never gets a grant.
        req = 4'b0100;
        @(negedge clk);
        check("withdraw_owner", 32'(gnt), 32'h4);
        req[0] = 1'b1;
        @(negedge clk);
        req[0] = 1'b0;
        repeat (2) @(negedge clk);
        req[2] = 1'b0;
        @(negedge clk);
        check("withdraw_gap", 32'(gnt), 32'h0);
        @(negedge clk);
        check("withdraw_idle_gnt", 32'(gnt), 32'h0);
        check("withdraw_idle_busy", 32'(busy), 32'h0);
        @(negedge clk);
        check("withdraw_still_idle", 32'(gnt), 32'h0);

        // Randomized traffic: requests tend to stay up so holds and preemptions occur.
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < NREQ; b++) begin
                if (req[b]) begin
                    if ($urandom_range(39, 0) == 0) req[b] = 1'b0;
                end else begin
                    if ($urandom_range(5, 0) == 0) req[b] = 1'b1;
                end
            end
            @(negedge clk);
        end

        // Asynchronous reset between edges while a grant is active.
        req = 4'b1111;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'h1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst_gnt", 32'(gnt), 32'h0);
        check("async_rst_busy", 32'(busy), 32'h0);
        req = 4'b0110;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_gnt", 32'(gnt), 32'h2);
        check("post_rst_gnt_id", 32'(gnt_id), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/req_gnt_arbiter.md
# req_gnt_arbiter

Round-robin arbiter that shares a single request/grant slave between `NREQ` masters. Each master raises its `req` and holds it for as long as it needs the resource. The arbiter grants exactly one master at a time and revokes the grant when that master drops `req`. An optional hold limit forcibly preempts an owner that starves other masters. The block sits between the masters' `req` outputs and the `gnt` inputs of the master/slave pairs.

## Interface
- `NREQ`, 4, number of requesters (2..16)
- `MAX_HOLD`, 16, max consecutive grant cycles before preemption when others wait; 0 disables preemption
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req`  in  NREQ  per-master request, level, held while owning
- `gnt`  out  NREQ  one-hot grant, registered
- `gnt_id`  out  $clog2(NREQ)  index of current owner; valid when `busy`
- `busy`  out  1  a grant is active
- `preempt`  out  1  one-cycle pulse: owner was revoked by hold limit

## Operation
- Reset values:
  - state IDLE
  - `gnt`=0, `gnt_id`=0, `busy`=0, `preempt`=0
  - RR pointer=0 (master 0 highest priority)
  - hold counter=0
- States:
  - **IDLE**
    - no grant
    - if `req`≠0 → GRANT to the winner
  - **GRANT**
    - `gnt[owner]`=1
    - counter increments each cycle
    - if `req[owner]`=0 → RELEASE
    - else if `MAX_HOLD`≠0, counter=`MAX_HOLD`-1 and (`req` & ~owner-mask)≠0 → RELEASE with `preempt`=1
    - else stay
  - **RELEASE**
    - `gnt`=0 for exactly one turnaround cycle
    - arbitrates on `req` sampled this cycle: winner → GRANT, none → IDLE
- Winner selection: first set bit of `req` at or after the RR pointer, wrapping modulo `NREQ`.
  - On every grant, pointer ← winner+1 (mod `NREQ`).
- Preempted owner with `req` still high stays an ordinary requester. It is served again only after the others in rotation order.
- Withdrawal: a master dropping `req` before being granted has no effect and causes no grant.
- Owner's `req` is ignored while its `gnt` is low.
- Hold counter clears on entry to GRANT and saturates at `MAX_HOLD`-1 when no other requester waits. A lone owner is never preempted.
- `gnt` is never more than one-hot. `gnt_id`, `busy` and `gnt` change on the same edge.
- Reset asserted mid-grant clears `gnt` immediately (asynchronously). Arbitration restarts from master 0 after reset deasserts.

## Timing
- Grant latency from IDLE: `req` high before edge k → `gnt` high after edge k (1 cycle).
- Release: owner `req` low before edge k → `gnt` low after edge k.
  - Next owner's `gnt` high after edge k+1.
  - Minimum gap between two grants is 1 cycle.
- Preemption: with another request pending, `gnt` is high for exactly `MAX_HOLD` cycles.
  - `preempt` is high in the first RELEASE cycle only.
- Simultaneous requests in IDLE resolve in one cycle by RR order.
- No combinational path from `req` to any output.

## Structure
- Package `req_gnt_pkg`:
  - state enum (IDLE, GRANT, RELEASE)
  - `idx_w(n)` width function
  - default `NREQ` / `MAX_HOLD` constants
- Sub-module `rr_pick`: combinational rotate-and-priority-encode. Inputs `req` and pointer; outputs winner index and `found`. Reused in IDLE and RELEASE.
- Top: state register, pointer, hold counter, output registers.

## Test plan
- Reset with `req`=4'b1111 → all outputs 0. After `rst` high, `gnt`=0001 one cycle later, `gnt_id`=0.
- `req`=4'b1111 held, each owner drops `req` after 3 cycles and raises again → grant order 0,1,2,3,0, one idle cycle between grants.
- `req[2]` alone held 40 cycles, `MAX_HOLD`=16 → `gnt`=0100 for all 40 cycles, `preempt` never asserted.
- `req[1]` held, `req[3]` raised at cycle 5 → `gnt[1]` drops after its 16th cycle, `preempt` pulses once, `gnt`=1000 the next cycle.
- `req[0]` pulses high for 1 cycle while master 2 owns → no grant to master 0 after release; returns to IDLE.
- `rst` driven low mid-GRANT, between clock edges → `gnt`=0 immediately. After release, the first grant goes to the lowest-index active requester.
